// File: rtl/rmw_seq_pkg.sv
// rmw_seq_pkg
// Shared types for the read-modify-write sequencer: the decoder's RmwOp
// codes, the sequencer state encoding and the ALU function selector that
// the shared CPU ALU understands.
package rmw_seq_pkg;

    // Operation codes from the instruction decoder; codes 6 and 7 are
    // reserved and handled as a plain pass-through write-back.
    typedef enum logic [2:0] {
        RMWASL = 3'd0,
        RMWLSR = 3'd1,
        RMWROL = 3'd2,
        RMWROR = 3'd3,
        RMWINC = 3'd4,
        RMWDEC = 3'd5
    } RmwOp;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DUMMY = 2'd2,
        WRITE = 2'd3
    } RmwState;

    // Function select of the shared CPU ALU.
    typedef enum logic [2:0] {
        ALUTXA = 3'd0,
        ALUADD = 3'd1,
        ALUSUB = 3'd2,
        ALUROL = 3'd3,
        ALUROR = 3'd4
    } ALUFunc;

    localparam logic [7:0] ALU_ONE = 8'h01;

endpackage

// File: rtl/rmw_alu_map.sv
// rmw_alu_map
// Purely combinational decode of an RmwOp (plus the carry latched at
// accept) into the ALU control fields and the flag-update enables.
// Ports:
//   op      in  3  latched RmwOp code
//   cy      in  1  carry flag latched at accept
//   func    out    ALU function select
//   in_b    out 8  ALU operand B
//   cin     out 1  ALU carry in
//   cinclr  out 1  ALU carry-in clear
//   nz_en   out 1  operation updates N and Z
//   c_en    out 1  operation updates C
module rmw_alu_map
    import rmw_seq_pkg::*;
(
    input  logic [2:0] op,
    input  logic       cy,
    output ALUFunc     func,
    output logic [7:0] in_b,
    output logic       cin,
    output logic       cinclr,
    output logic       nz_en,
    output logic       c_en
);

    always_comb begin
        func   = ALUTXA;
        in_b   = 8'h00;
        cin    = 1'b0;
        cinclr = 1'b1;
        nz_en  = 1'b0;
        c_en   = 1'b0;
        case (op)
            RMWASL: begin
                func  = ALUROL;
                nz_en = 1'b1;
                c_en  = 1'b1;
            end
            RMWLSR: begin
                func  = ALUROR;
                nz_en = 1'b1;
                c_en  = 1'b1;
            end
            // Rotates feed the old carry in, so the clear must be released.
            RMWROL: begin
                func   = ALUROL;
                cin    = cy;
                cinclr = 1'b0;
                nz_en  = 1'b1;
                c_en   = 1'b1;
            end
            RMWROR: begin
                func   = ALUROR;
                cin    = cy;
                cinclr = 1'b0;
                nz_en  = 1'b1;
                c_en   = 1'b1;
            end
            RMWINC: begin
                func  = ALUADD;
                in_b  = ALU_ONE;
                nz_en = 1'b1;
            end
            // Carry-in cleared means no borrow, so the result is a - 1.
            RMWDEC: begin
                func  = ALUSUB;
                in_b  = ALU_ONE;
                nz_en = 1'b1;
            end
            default: begin
                func = ALUTXA;
            end
        endcase
    end

endmodule

// File: rtl/rmw_seq.sv
// rmw_seq
// Sequencer for 6502 read-modify-write memory instructions. Accepts one
// decoder request, performs the operand read, the dummy write of the
// unmodified value, then the final write of the modified value, and
// returns N/Z/C updates together with a one-cycle done pulse.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   req_valid/req_ready/req_op/req_addr/flag_c   decoder request
//   bus_addr/bus_rd/bus_wr/bus_dout/bus_din/bus_rdy  CPU bus interface
//   alu_in_a/alu_in_b/alu_func/alu_cin/alu_cinclr    shared ALU drive
//   alu_out/alu_cout/alu_zero/alu_sign               shared ALU results
//   flag_nz_we/flag_c_we/flag_n/flag_z/flag_c_out    status register update
//   done                            one-cycle completion pulse
module rmw_seq
    import rmw_seq_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [AW-1:0] req_addr,
    input  logic          flag_c,
    output logic [AW-1:0] bus_addr,
    output logic          bus_rd,
    output logic          bus_wr,
    output logic [7:0]    bus_dout,
    input  logic [7:0]    bus_din,
    input  logic          bus_rdy,
    output logic [7:0]    alu_in_a,
    output logic [7:0]    alu_in_b,
    output ALUFunc        alu_func,
    output logic          alu_cin,
    output logic          alu_cinclr,
    input  logic [7:0]    alu_out,
    input  logic          alu_cout,
    input  logic          alu_zero,
    input  logic          alu_sign,
    output logic          flag_nz_we,
    output logic          flag_c_we,
    output logic          flag_n,
    output logic          flag_z,
    output logic          flag_c_out,
    output logic          done
);

    RmwState       state;
    logic [2:0]    op_l;
    logic [AW-1:0] addr_l;
    logic          cy_l;
    logic [7:0]    data_l;
    logic          n_l;
    logic          z_l;
    logic          c_l;

    ALUFunc        map_func;
    logic [7:0]    map_b;
    logic          map_cin;
    logic          map_cinclr;
    logic          map_nz_en;
    logic          map_c_en;
    logic          in_dummy;

    rmw_alu_map u_map (
        .op     (op_l),
        .cy     (cy_l),
        .func   (map_func),
        .in_b   (map_b),
        .cin    (map_cin),
        .cinclr (map_cinclr),
        .nz_en  (map_nz_en),
        .c_en   (map_c_en)
    );

    assign req_ready = (state == IDLE);
    assign bus_addr  = addr_l;

    // The ALU is shared with the rest of the CPU, so it only sees our
    // operand during DUMMY and a neutral pass-through drive otherwise.
    assign in_dummy   = (state == DUMMY);
    assign alu_func   = in_dummy ? map_func : ALUTXA;
    assign alu_in_a   = in_dummy ? data_l : 8'h00;
    assign alu_in_b   = in_dummy ? map_b : 8'h00;
    assign alu_cin    = in_dummy & map_cin;
    assign alu_cinclr = in_dummy ? map_cinclr : 1'b1;

    // bus_dout doubles as the result register: it takes the ALU result at
    // the end of DUMMY and holds it for the whole of WRITE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            op_l       <= 3'd0;
            addr_l     <= '0;
            cy_l       <= 1'b0;
            data_l     <= 8'h00;
            n_l        <= 1'b0;
            z_l        <= 1'b0;
            c_l        <= 1'b0;
            bus_rd     <= 1'b0;
            bus_wr     <= 1'b0;
            bus_dout   <= 8'h00;
            done       <= 1'b0;
            flag_nz_we <= 1'b0;
            flag_c_we  <= 1'b0;
            flag_n     <= 1'b0;
            flag_z     <= 1'b0;
            flag_c_out <= 1'b0;
        end else begin
            done       <= 1'b0;
            flag_nz_we <= 1'b0;
            flag_c_we  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_l   <= req_op;
                        addr_l <= req_addr;
                        cy_l   <= flag_c;
                        bus_rd <= 1'b1;
                        state  <= READ;
                    end
                end
                READ: begin
                    if (bus_rdy) begin
                        data_l   <= bus_din;
                        bus_rd   <= 1'b0;
                        bus_wr   <= 1'b1;
                        bus_dout <= bus_din;
                        state    <= DUMMY;
                    end
                end
                DUMMY: begin
                    if (bus_rdy) begin
                        bus_dout <= alu_out;
                        n_l      <= alu_sign;
                        z_l      <= alu_zero;
                        c_l      <= alu_cout;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (bus_rdy) begin
                        bus_wr <= 1'b0;
                        done   <= 1'b1;
                        if (map_nz_en) begin
                            flag_nz_we <= 1'b1;
                            flag_n     <= n_l;
                            flag_z     <= z_l;
                        end
                        if (map_c_en) begin
                            flag_c_we  <= 1'b1;
                            flag_c_out <= c_l;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rmw_seq.sv
// tb_rmw_seq
// Directed bench for rmw_seq. A behavioural ALU stands in for the CPU ALU,
// a transaction-level model predicts each operation's result, flags and
// completion cycle, and a per-cycle compare process checks the bus, the
// handshake and the flag outputs against that model.
module tb_rmw_seq;
    import rmw_seq_pkg::*;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [AW-1:0] req_addr;
    logic          flag_c;
    logic [AW-1:0] bus_addr;
    logic          bus_rd;
    logic          bus_wr;
    logic [7:0]    bus_dout;
    logic [7:0]    bus_din;
    logic          bus_rdy;
    logic [7:0]    alu_in_a;
    logic [7:0]    alu_in_b;
    ALUFunc        alu_func;
    logic          alu_cin;
    logic          alu_cinclr;
    logic [7:0]    alu_out;
    logic          alu_cout;
    logic          alu_zero;
    logic          alu_sign;
    logic          flag_nz_we;
    logic          flag_c_we;
    logic          flag_n;
    logic          flag_z;
    logic          flag_c_out;
    logic          done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Transaction model state
    bit         active = 1'b0;
    int         expDone = -1;
    logic [15:0] expAddr = 16'h0000;
    logic [7:0] expDin = 8'h00;
    logic [7:0] expRes = 8'h00;
    logic       expNzEn = 1'b0;
    logic       expCEn = 1'b0;
    logic       newN = 1'b0;
    logic       newZ = 1'b0;
    logic       newC = 1'b0;
    logic       expN = 1'b0;
    logic       expZ = 1'b0;
    logic       expC = 1'b0;
    int         wrSeen = 0;
    bit         readDone = 1'b0;
    logic [7:0] lastWrite = 8'h00;
    int         lastWait = 0;

    rmw_seq #(.AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .flag_c     (flag_c),
        .bus_addr   (bus_addr),
        .bus_rd     (bus_rd),
        .bus_wr     (bus_wr),
        .bus_dout   (bus_dout),
        .bus_din    (bus_din),
        .bus_rdy    (bus_rdy),
        .alu_in_a   (alu_in_a),
        .alu_in_b   (alu_in_b),
        .alu_func   (alu_func),
        .alu_cin    (alu_cin),
        .alu_cinclr (alu_cinclr),
        .alu_out    (alu_out),
        .alu_cout   (alu_cout),
        .alu_zero   (alu_zero),
        .alu_sign   (alu_sign),
        .flag_nz_we (flag_nz_we),
        .flag_c_we  (flag_c_we),
        .flag_n     (flag_n),
        .flag_z     (flag_z),
        .flag_c_out (flag_c_out),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the shared CPU ALU.
    logic [8:0] aluWide;
    logic       cinEff;
    always_comb begin
        cinEff  = alu_cin & ~alu_cinclr;
        aluWide = {1'b0, alu_in_a};
        case (alu_func)
            ALUROL:  aluWide = {alu_in_a, cinEff};
            ALUROR:  aluWide = {alu_in_a[0], cinEff, alu_in_a[7:1]};
            ALUADD:  aluWide = {1'b0, alu_in_a} + {1'b0, alu_in_b} + {8'h00, cinEff};
            ALUSUB:  aluWide = {1'b0, alu_in_a} - {1'b0, alu_in_b} - {8'h00, ~alu_cinclr & ~alu_cin};
            default: aluWide = {1'b0, alu_in_a};
        endcase
    end
    assign alu_out  = aluWide[7:0];
    assign alu_cout = aluWide[8];
    assign alu_zero = (aluWide[7:0] == 8'h00);
    assign alu_sign = aluWide[7];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // What an RMW instruction does to its operand, straight from the
    // instruction definitions.
    function automatic void modelTxn(input logic [2:0] op, input logic [7:0] din, input logic cin,
                                     output logic [7:0] res, output logic nzEn, output logic cEn,
                                     output logic n, output logic z, output logic c);
        c    = 1'b0;
        nzEn = (op <= 3'd5);
        cEn  = (op <= 3'd3);
        case (op)
            3'd0: begin res = {din[6:0], 1'b0}; c = din[7]; end
            3'd1: begin res = {1'b0, din[7:1]}; c = din[0]; end
            3'd2: begin res = {din[6:0], cin};  c = din[7]; end
            3'd3: begin res = {cin, din[7:1]};  c = din[0]; end
            3'd4: res = din + 8'd1;
            3'd5: res = din - 8'd1;
            default: res = din;
        endcase
        n = res[7];
        z = (res == 8'h00);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Per-cycle comparison against the transaction model.
    initial begin
        bit inWin;
        bit isDone;
        forever begin
            @(negedge clk);
            inWin  = active && (cyc < expDone);
            isDone = active && (cyc == expDone);
            checkOutput("rd_wr_exclusive", 32'(bus_rd & bus_wr), 32'd0);
            checkOutput("done_timing", 32'(done), 32'(isDone));
            checkOutput("req_ready", 32'(req_ready), 32'(!inWin));
            checkOutput("bus_busy", 32'(bus_rd | bus_wr), 32'(inWin));
            if (bus_rd) begin
                checkOutput("read_addr", 32'(bus_addr), 32'(expAddr));
                checkOutput("read_order", 32'(wrSeen), 32'd0);
                if (bus_rdy) readDone = 1'b1;
            end
            if (bus_wr) begin
                checkOutput("write_addr", 32'(bus_addr), 32'(expAddr));
                checkOutput("write_after_read", 32'(readDone), 32'd1);
                checkOutput("write_data", 32'(bus_dout), 32'((wrSeen == 0) ? expDin : expRes));
                if (bus_rdy) begin
                    lastWrite = bus_dout;
                    wrSeen++;
                end
            end
            if (isDone) begin
                if (expNzEn) begin
                    expN = newN;
                    expZ = newZ;
                end
                if (expCEn) expC = newC;
            end
            checkOutput("nz_strobe", 32'(flag_nz_we), 32'(isDone && expNzEn));
            checkOutput("c_strobe", 32'(flag_c_we), 32'(isDone && expCEn));
            checkOutput("flag_n", 32'(flag_n), 32'(expN));
            checkOutput("flag_z", 32'(flag_z), 32'(expZ));
            checkOutput("flag_c_out", 32'(flag_c_out), 32'(expC));
        end
    end

    // Issues one request and steps the bus through read, dummy write and
    // final write, stalling each phase for the given number of cycles.
    // With early set, a second request is raised during the WRITE stall.
    task automatic applyStimulus(input logic [2:0] op, input logic [15:0] addr, input logic [7:0] din,
                                 input logic cin, input int hR, input int hD, input int hW,
                                 input bit early, input logic [2:0] eOp, input logic [15:0] eAddr);
        int waitCnt;
        int hold;
        req_op    = op;
        req_addr  = addr;
        flag_c    = cin;
        req_valid = 1'b1;
        bus_din   = din;
        bus_rdy   = 1'b1;
        waitCnt   = 0;
        while (!req_ready && waitCnt < 50) begin
            @(posedge clk);
            #1;
            waitCnt++;
        end
        lastWait = waitCnt;
        if (waitCnt == 50) begin
            checkOutput("ready_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        modelTxn(op, din, cin, expRes, expNzEn, expCEn, newN, newZ, newC);
        active   = 1'b1;
        expAddr  = addr;
        expDin   = din;
        wrSeen   = 0;
        readDone = 1'b0;
        expDone  = cyc + 3 + hR + hD + hW;
        for (int p = 0; p < 3; p++) begin
            hold = (p == 0) ? hR : ((p == 1) ? hD : hW);
            repeat (hold) begin
                bus_rdy = 1'b0;
                if (p == 2 && early) begin
                    req_valid = 1'b1;
                    req_op    = eOp;
                    req_addr  = eAddr;
                end
                @(posedge clk);
                #1;
            end
            bus_rdy = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_addr  = 16'h0000;
        flag_c    = 1'b0;
        bus_din   = 8'h00;
        bus_rdy   = 1'b1;
        #1 reset = 1'b1;
        #2;
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_bus_rd", 32'(bus_rd), 32'd0);
        checkOutput("rst_bus_wr", 32'(bus_wr), 32'd0);
        checkOutput("rst_bus_addr", 32'(bus_addr), 32'd0);
        checkOutput("rst_bus_dout", 32'(bus_dout), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_strobes", 32'({flag_nz_we, flag_c_we}), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        $display("[TB] reset released");

        // ASL of 8'h81 at 16'h0200
        applyStimulus(3'd0, 16'h0200, 8'h81, 1'b0, 0, 0, 0, 1'b0, 3'd0, 16'h0000);
        checkOutput("asl_done", 32'(done), 32'd1);
        checkOutput("asl_write", 32'(lastWrite), 32'h02);
        checkOutput("asl_nzc", 32'({flag_n, flag_z, flag_c_out}), 32'b001);
        checkOutput("asl_strobes", 32'({flag_nz_we, flag_c_we}), 32'b11);

        // ROR of 8'h01 with carry in set
        applyStimulus(3'd3, 16'h0210, 8'h01, 1'b1, 0, 0, 0, 1'b0, 3'd0, 16'h0000);
        checkOutput("ror_write", 32'(lastWrite), 32'h80);
        checkOutput("ror_nzc", 32'({flag_n, flag_z, flag_c_out}), 32'b101);

        // INC wrap-around: carry is not touched
        applyStimulus(3'd4, 16'h0220, 8'hFF, 1'b0, 0, 0, 0, 1'b0, 3'd0, 16'h0000);
        checkOutput("inc_write", 32'(lastWrite), 32'h00);
        checkOutput("inc_nzc", 32'({flag_n, flag_z, flag_c_out}), 32'b011);
        checkOutput("inc_strobes", 32'({flag_nz_we, flag_c_we}), 32'b10);

        // DEC wrap-around with three stall cycles in every phase
        applyStimulus(3'd5, 16'h0230, 8'h00, 1'b0, 3, 3, 3, 1'b0, 3'd0, 16'h0000);
        checkOutput("dec_done", 32'(done), 32'd1);
        checkOutput("dec_write", 32'(lastWrite), 32'hFF);
        checkOutput("dec_nz", 32'({flag_n, flag_z}), 32'b10);

        // ROL aborted by reset in the middle of the dummy write
        req_op    = 3'd2;
        req_addr  = 16'h0240;
        flag_c    = 1'b1;
        bus_din   = 8'hC3;
        bus_rdy   = 1'b1;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        modelTxn(3'd2, 8'hC3, 1'b1, expRes, expNzEn, expCEn, newN, newZ, newC);
        active   = 1'b1;
        expAddr  = 16'h0240;
        expDin   = 8'hC3;
        wrSeen   = 0;
        readDone = 1'b0;
        expDone  = cyc + 1000;
        @(posedge clk);
        #1;
        bus_rdy = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("abort_in_dummy", 32'(bus_wr), 32'd1);
        reset  = 1'b1;
        active = 1'b0;
        expN   = 1'b0;
        expZ   = 1'b0;
        expC   = 1'b0;
        #1;
        checkOutput("abort_bus_wr", 32'(bus_wr), 32'd0);
        checkOutput("abort_bus_rd", 32'(bus_rd), 32'd0);
        checkOutput("abort_req_ready", 32'(req_ready), 32'd1);
        checkOutput("abort_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        bus_rdy = 1'b1;

        // LSR of 8'h01 after the abort
        applyStimulus(3'd1, 16'h0250, 8'h01, 1'b0, 0, 0, 0, 1'b0, 3'd0, 16'h0000);
        checkOutput("lsr_write", 32'(lastWrite), 32'h00);
        checkOutput("lsr_nzc", 32'({flag_n, flag_z, flag_c_out}), 32'b011);

        // INC with a second request raised while WRITE is stalled
        applyStimulus(3'd4, 16'h0260, 8'h10, 1'b0, 0, 0, 2, 1'b1, 3'd7, 16'h0300);
        checkOutput("inc2_write", 32'(lastWrite), 32'h11);
        checkOutput("inc2_ready", 32'(req_ready), 32'd1);

        // The held request (reserved op 7) is accepted in the done cycle
        applyStimulus(3'd7, 16'h0300, 8'h5A, 1'b0, 0, 0, 0, 1'b0, 3'd0, 16'h0000);
        checkOutput("rsv_accept_wait", 32'(lastWait), 32'd0);
        checkOutput("rsv_done", 32'(done), 32'd1);
        checkOutput("rsv_write", 32'(lastWrite), 32'h5A);
        checkOutput("rsv_strobes", 32'({flag_nz_we, flag_c_we}), 32'b00);
        checkOutput("rsv_nzc", 32'({flag_n, flag_z, flag_c_out}), 32'b001);

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
